mutex_bank: RTL and testbench
=============================

# mutex_bank

Parametrised bank of hardware mutexes on the cluster device bus, for inter-core locking. Generalises the fixed two-mutex scheme to NUM_LOCKS locks, adding recursive (nested) acquisition by the owning core, a held-status bitmask register and optional per-lock contention counters. Sits beside the cluster in the top level, decodes its own address window and returns registered read data on device_data_in.

## Interface
- NUM_LOCKS, 2: number of mutexes, 1..16.
- CORE_ID_WIDTH, 4: width of device_core_id.
- BASE_ADDR, 10'h3fe: address of lock 0; lock i at BASE_ADDR - i.
- DEPTH_W, 4: width of per-lock recursion depth counter.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- device_core_id  in  CORE_ID_WIDTH  requesting core.
- device_write_en  in  1  bus write strobe.
- device_read_en  in  1  bus read strobe.
- device_addr  in  10  word address.
- device_data_out  in  16  write data from cluster.
- device_data_in  out  16  registered read data to cluster.
- device_read_valid  out  1  high for one cycle when device_data_in was loaded by a hit read.

## Operation
- Per lock: held bit, holder id (CORE_ID_WIDTH), depth (DEPTH_W, unsigned).
- Lock register, write nonzero:
  - free -> held=1, holder=core_id, depth=1.
  - held by same core -> depth+1, saturating at 2^DEPTH_W-1 (no wrap).
  - held by other core -> no change (failed acquire).
- Lock register, write zero:
  - held by same core, depth>1 -> depth-1.
  - held by same core, depth==1 -> held=0, depth=0; holder retains its last value.
  - not held, or held by other core -> ignored.
- Lock register read: data_in = {15'b0, held && holder==core_id}.
- Status register at BASE_ADDR - NUM_LOCKS: read returns bit i = held[i], upper bits 0; writes ignored.
- Read-only data_in update: only on read_en with write_en low and address in window; otherwise data_in holds previous value.
- write_en and read_en both high: write performed, read ignored, data_in unchanged, read_valid 0.
- Address outside window: no state change, data_in unchanged, read_valid 0.

## Timing
- Reset values: data_in=0, read_valid=0, all held=0, holder=0, depth=0, counters=0.
- Write effect visible to a read issued the following cycle.
- Read latency 1: data_in and read_valid update at the edge sampling read_en.
- Back-to-back accesses every cycle supported; one access per cycle by bus construction.
- Reset asserted mid-operation clears all locks immediately regardless of owners.

## Configuration
- MUTEX_BANK_STATS_EN defined: each lock has a 16-bit contention counter, +1 on every failed acquire, saturating at 16'hffff. Counter i read at BASE_ADDR - NUM_LOCKS - 1 - i; read returns value and clears it to 0 at the same edge. Writes to counter addresses ignored.
- Undefined: no counters, no counter addresses decoded; those addresses behave as out-of-window.

## Structure
- Package mutex_bank_pkg: DATA_W=16, ADDR_W=10, status/counter offset constants, lock-state struct typedef (held, holder, depth).
- Sub-module mutex_slot: one lock's state, acquire/release/recursion logic and optional counter; mutex_bank instantiates NUM_LOCKS via generate and performs address decode and read mux.

## Test plan
- After reset, core 3 reads lock 0 -> data_in=0, read_valid=1 next cycle; status read -> 16'h0000.
- Core 3 writes 1 to lock 0, core 5 writes 1 to lock 0 -> core 3 read =1, core 5 read =0, status=16'h0001.
- Core 3 writes 1 twice more (depth 3), writes 0 twice -> still held; third 0 write -> status=0; core 5 acquire then succeeds.
- Core 5 writes 0 to lock held by core 3 -> ignored, core 3 still reads 1.
- Depth saturation: 20 nested acquires with DEPTH_W=4 -> 15 releases free the lock.
- MUTEX_BANK_STATS_EN: 3 failed acquires on lock 1 -> counter read =3, immediate re-read =0; simultaneous read_en+write_en -> data_in unchanged.

Source files
------------

// File: rtl/mutex_bank_pkg.sv
// Shared constants and types for the mutex bank.
package mutex_bank_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 10;

  // Storage widths for lock state; these are the upper bounds on CORE_ID_WIDTH and DEPTH_W.
  localparam int unsigned ID_MAX_W    = 8;
  localparam int unsigned DEPTH_MAX_W = 8;

  typedef struct packed {
    logic                   held;
    logic [ID_MAX_W-1:0]    holder;
    logic [DEPTH_MAX_W-1:0] depth;
  } lock_state_t;

  // Offset below the base address of the held-status register.
  function automatic int unsigned status_offset(input int unsigned num_locks);
    return num_locks;
  endfunction

  // Offset below the base address of contention counter idx.
  function automatic int unsigned cnt_offset(input int unsigned num_locks,
                                             input int unsigned idx);
    return num_locks + 1 + idx;
  endfunction

endpackage

// File: rtl/mutex_bank_if.sv
// Cluster device-bus signals seen by the mutex bank.
interface mutex_bank_if #(
  parameter int unsigned CORE_ID_WIDTH = 4
);
  logic [CORE_ID_WIDTH-1:0] device_core_id;
  logic                     device_write_en;
  logic                     device_read_en;
  logic [9:0]               device_addr;
  logic [15:0]              device_data_out;
  logic [15:0]              device_data_in;
  logic                     device_read_valid;

  modport master (
    output device_core_id, device_write_en, device_read_en, device_addr, device_data_out,
    input  device_data_in, device_read_valid
  );

  modport slave (
    input  device_core_id, device_write_en, device_read_en, device_addr, device_data_out,
    output device_data_in, device_read_valid
  );
endinterface

// File: rtl/mutex_slot.sv
// One recursive mutex: acquire, nested re-acquire, release and optional contention counter.
// MUTEX_BANK_STATS_EN adds the 16-bit clear-on-read contention counter.
module mutex_slot
  import mutex_bank_pkg::*;
#(
  parameter int unsigned CORE_ID_WIDTH = 4,
  parameter int unsigned DEPTH_W       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CORE_ID_WIDTH-1:0] core_id,
  input  logic                     wr,
  input  logic                     set,
`ifdef MUTEX_BANK_STATS_EN
  input  logic                     cnt_clr,
  output logic [DATA_W-1:0]        count,
`endif
  output logic                     held,
  output logic                     owned
);

  localparam logic [DEPTH_MAX_W-1:0] DEPTH_SAT = DEPTH_MAX_W'((1 << DEPTH_W) - 1);
  localparam logic [DEPTH_MAX_W-1:0] DEPTH_ONE = DEPTH_MAX_W'(1);

  lock_state_t         state;
  lock_state_t         state_next;
  logic [ID_MAX_W-1:0] id_ext;
  logic                same_core;

  assign id_ext    = ID_MAX_W'(core_id);
  assign same_core = state.holder == id_ext;
  assign held      = state.held;
  assign owned     = state.held && same_core;

`ifdef MUTEX_BANK_STATS_EN
  logic              fail;
  logic [DATA_W-1:0] count_next;
`endif

  // Next lock state from a write to this lock's register.
  always_comb begin
    state_next = state;
`ifdef MUTEX_BANK_STATS_EN
    fail = 1'b0;
`endif
    if (wr) begin
      if (set) begin
        if (!state.held) begin
          state_next.held   = 1'b1;
          state_next.holder = id_ext;
          state_next.depth  = DEPTH_ONE;
        end else if (same_core) begin
          if (state.depth != DEPTH_SAT) state_next.depth = state.depth + DEPTH_ONE;
        end else begin
`ifdef MUTEX_BANK_STATS_EN
          fail = 1'b1;
`endif
        end
      end else if (owned) begin
        if (state.depth > DEPTH_ONE) begin
          state_next.depth = state.depth - DEPTH_ONE;
        end else begin
          // Holder id is left as-is on final release.
          state_next.held  = 1'b0;
          state_next.depth = '0;
        end
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= '0;
    else       state <= state_next;
  end

`ifdef MUTEX_BANK_STATS_EN
  // Counter next value: clear on read, otherwise saturating count of failed acquires.
  always_comb begin
    count_next = count;
    if (cnt_clr)                      count_next = '0;
    else if (fail && count != 16'hffff) count_next = count + 16'd1;
  end

  // Contention counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count_next;
  end
`endif

endmodule

// File: rtl/mutex_bank.sv
// Bank of NUM_LOCKS recursive hardware mutexes on the cluster device bus.
// Lock i at BASE_ADDR - i, status at BASE_ADDR - NUM_LOCKS; with MUTEX_BANK_STATS_EN,
// counter i at BASE_ADDR - NUM_LOCKS - 1 - i.
module mutex_bank
  import mutex_bank_pkg::*;
#(
  parameter int unsigned       NUM_LOCKS     = 2,
  parameter int unsigned       CORE_ID_WIDTH = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 10'h3fe,
  parameter int unsigned       DEPTH_W       = 4
) (
  input logic         clk,
  input logic         reset,
  mutex_bank_if.slave bus
);

  logic [ADDR_W-1:0]    offset;
  logic [NUM_LOCKS-1:0] lock_sel;
  logic [NUM_LOCKS-1:0] held;
  logic [NUM_LOCKS-1:0] owned;
  logic                 status_sel;
  logic                 in_window;
  logic                 rd_hit;
  logic [DATA_W-1:0]    rdata;

  // Distance below the base address; window entries are at small offsets.
  assign offset = BASE_ADDR - bus.device_addr;

`ifdef MUTEX_BANK_STATS_EN
  logic [NUM_LOCKS-1:0] cnt_sel;
  logic [DATA_W-1:0]    count [NUM_LOCKS];
`endif

  // Address decode into one-hot lock, status and counter selects.
  always_comb begin
    lock_sel = '0;
    for (int unsigned i = 0; i < NUM_LOCKS; i++) begin
      lock_sel[i] = offset == ADDR_W'(i);
    end
    status_sel = offset == ADDR_W'(status_offset(NUM_LOCKS));
    in_window  = (|lock_sel) || status_sel;
`ifdef MUTEX_BANK_STATS_EN
    cnt_sel = '0;
    for (int unsigned i = 0; i < NUM_LOCKS; i++) begin
      cnt_sel[i] = offset == ADDR_W'(cnt_offset(NUM_LOCKS, i));
    end
    in_window = in_window || (|cnt_sel);
`endif
  end

  // A write takes priority; a concurrent read is dropped.
  assign rd_hit = bus.device_read_en && !bus.device_write_en && in_window;

  for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_slot
    mutex_slot #(
      .CORE_ID_WIDTH (CORE_ID_WIDTH),
      .DEPTH_W       (DEPTH_W)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .core_id (bus.device_core_id),
      .wr      (bus.device_write_en && lock_sel[g]),
      .set     (|bus.device_data_out),
`ifdef MUTEX_BANK_STATS_EN
      .cnt_clr (rd_hit && cnt_sel[g]),
      .count   (count[g]),
`endif
      .held    (held[g]),
      .owned   (owned[g])
    );
  end

  // Read data mux over the selected register.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_LOCKS; i++) begin
      if (lock_sel[i]) rdata = DATA_W'(owned[i]);
    end
    if (status_sel) rdata = DATA_W'(held);
`ifdef MUTEX_BANK_STATS_EN
    for (int unsigned i = 0; i < NUM_LOCKS; i++) begin
      if (cnt_sel[i]) rdata = count[i];
    end
`endif
  end

  // Registered read data and one-cycle valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.device_data_in    <= '0;
      bus.device_read_valid <= 1'b0;
    end else begin
      bus.device_read_valid <= rd_hit;
      if (rd_hit) bus.device_data_in <= rdata;
    end
  end

endmodule

// File: tb/tb_mutex_bank.sv
// Directed testbench for mutex_bank with default parameters.
module tb_mutex_bank;

  localparam logic [9:0] LOCK0  = 10'h3fe;
  localparam logic [9:0] LOCK1  = 10'h3fd;
  localparam logic [9:0] STATUS = 10'h3fc;
  localparam logic [9:0] CNT0   = 10'h3fb;
  localparam logic [9:0] CNT1   = 10'h3fa;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  mutex_bank_if #(.CORE_ID_WIDTH(4)) bus ();

  mutex_bank #(
    .NUM_LOCKS     (2),
    .CORE_ID_WIDTH (4),
    .BASE_ADDR     (10'h3fe),
    .DEPTH_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One bus access: driven at the falling edge, sampled 1 ns after the rising edge.
  task automatic access(input logic [3:0] core, input logic we, input logic re,
                        input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.device_core_id  = core;
    bus.device_write_en = we;
    bus.device_read_en  = re;
    bus.device_addr     = a;
    bus.device_data_out = d;
    @(posedge clk);
    #1;
    bus.device_write_en = 1'b0;
    bus.device_read_en  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] core, input logic [9:0] a, input logic [15:0] d);
    access(core, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input string tag, input logic [3:0] core, input logic [9:0] a,
                    input logic [15:0] exp);
    access(core, 1'b0, 1'b1, a, 16'h0);
    check({tag, "_valid"}, {15'b0, bus.device_read_valid}, 16'h1);
    check(tag, bus.device_data_in, exp);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    bus.device_core_id  = '0;
    bus.device_write_en = 1'b0;
    bus.device_read_en  = 1'b0;
    bus.device_addr     = '0;
    bus.device_data_out = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data", bus.device_data_in, 16'h0);
    check("rst_valid", {15'b0, bus.device_read_valid}, 16'h0);
    reset = 1'b0;

    rd("rd0_c3", 4'd3, LOCK0, 16'h0);
    rd("status_empty", 4'd3, STATUS, 16'h0);

    wr(4'd3, LOCK0, 16'h1);
    wr(4'd5, LOCK0, 16'h1);
    rd("own_c3", 4'd3, LOCK0, 16'h1);
    rd("own_c5", 4'd5, LOCK0, 16'h0);
    rd("status_l0", 4'd5, STATUS, 16'h1);

    // Nest to depth 3, then unwind.
    wr(4'd3, LOCK0, 16'h1);
    wr(4'd3, LOCK0, 16'h1);
    wr(4'd3, LOCK0, 16'h0);
    wr(4'd3, LOCK0, 16'h0);
    rd("nest_held", 4'd3, LOCK0, 16'h1);
    wr(4'd3, LOCK0, 16'h0);
    rd("nest_free", 4'd3, STATUS, 16'h0);
    wr(4'd5, LOCK0, 16'h1);
    rd("c5_acq", 4'd5, LOCK0, 16'h1);

    // Release by a non-owner is ignored.
    wr(4'd5, LOCK0, 16'h0);
    wr(4'd3, LOCK0, 16'h1);
    wr(4'd5, LOCK0, 16'h0);
    rd("foreign_rel", 4'd3, LOCK0, 16'h1);

    // Write: no valid, data held; out-of-window read likewise.
    wr(4'd3, LOCK1, 16'h0);
    check("wr_novalid", {15'b0, bus.device_read_valid}, 16'h0);
    check("wr_hold", bus.device_data_in, 16'h1);
    access(4'd3, 1'b0, 1'b1, 10'h100, 16'h0);
    check("oow_novalid", {15'b0, bus.device_read_valid}, 16'h0);
    check("oow_hold", bus.device_data_in, 16'h1);

    // Depth saturates at 15.
    for (int i = 0; i < 20; i++) wr(4'd2, LOCK1, 16'h1);
    for (int i = 0; i < 14; i++) wr(4'd2, LOCK1, 16'h0);
    rd("sat_held", 4'd2, LOCK1, 16'h1);
    rd("sat_status", 4'd2, STATUS, 16'h3);
    wr(4'd2, LOCK1, 16'h0);
    rd("sat_free", 4'd2, STATUS, 16'h1);

    // Simultaneous read and write: write wins, read dropped.
    access(4'd7, 1'b1, 1'b1, LOCK1, 16'h1);
    check("rw_novalid", {15'b0, bus.device_read_valid}, 16'h0);
    check("rw_hold", bus.device_data_in, 16'h1);
    rd("rw_acq", 4'd7, LOCK1, 16'h1);

`ifdef MUTEX_BANK_STATS_EN
    // Core 5 failed once on lock 0 earlier.
    rd("cnt0", 4'd1, CNT0, 16'h1);
    for (int i = 0; i < 3; i++) wr(4'd4, LOCK1, 16'h1);
    wr(4'd4, CNT1, 16'h0);
    rd("cnt1", 4'd4, CNT1, 16'h3);
    rd("cnt1_clr", 4'd4, CNT1, 16'h0);
`else
    access(4'd1, 1'b0, 1'b1, CNT0, 16'h0);
    check("cnt_oow_valid", {15'b0, bus.device_read_valid}, 16'h0);
    check("cnt_oow_hold", bus.device_data_in, 16'h1);
`endif

    // Asynchronous reset while both locks are held.
    rd("pre_rst_status", 4'd1, STATUS, 16'h3);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("async_data", bus.device_data_in, 16'h0);
    check("async_valid", {15'b0, bus.device_read_valid}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    rd("post_rst_status", 4'd3, STATUS, 16'h0);
    rd("post_rst_l0", 4'd3, LOCK0, 16'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
